// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path.
// Opcodes, FSM state codes, instruction classes, write-back and trap codes.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_LOAD, CLS_STORE, CLS_OP, CLS_OPIMM, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYSTEM
    } cls_t;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_PC4  = 2'b01;
    localparam logic [1:0] WB_LOAD = 2'b10;
    localparam logic [1:0] WB_ALU  = 2'b11;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Maps a 7-bit RV32I opcode to its instruction class and flags unknown opcodes.
// Purely combinational, zero latency; no flow control.
module opcode_classifier
    import rv32i_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output cls_t       o_cls,
    output logic       o_illegal
);

    always_comb begin
        o_cls     = CLS_NONE;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_LOAD:   o_cls = CLS_LOAD;
            OPC_STORE:  o_cls = CLS_STORE;
            OPC_OP:     o_cls = CLS_OP;
            OPC_OPIMM:  o_cls = CLS_OPIMM;
            OPC_BRANCH: o_cls = CLS_BRANCH;
            OPC_JAL:    o_cls = CLS_JAL;
            OPC_JALR:   o_cls = CLS_JALR;
            OPC_LUI:    o_cls = CLS_LUI;
            OPC_AUIPC:  o_cls = CLS_AUIPC;
            OPC_SYSTEM: o_cls = CLS_SYSTEM;
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control FSM with halt/resume, wait timeout trap and instret.
// 4 cycles per instruction minimum (5 for loads/stores), plus handshake wait cycles.
// Each wait stage holds its enable until the handshake; a wait of TIMEOUT cycles traps.
module multicycle_sequencer
    import rv32i_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             im_ready,
    input  logic             alu_valid,
    input  logic             dm_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             im_req,
    output logic             ir_load,
    output logic             rf_read_en,
    output logic             alu_en,
    output logic             dm_read_en,
    output logic             dm_write_en,
    output logic             rf_write_en,
    output logic             pc_en,
    output logic             pc_sel,
    output logic [1:0]       wb_sel,
    output logic [2:0]       stage,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [WIDTH-1:0] instret
);

    logic [2:0]       r_state;
    logic [TO_W-1:0]  r_wait_cnt;
    cls_t             r_cls;
    logic [1:0]       r_trap_cause;
    logic [WIDTH-1:0] r_instret;

    logic [2:0]       w_next;
    cls_t             w_cls;
    logic             w_illegal;
    logic             w_hs;
    logic             w_wait_state;
    logic             w_timeout;
    logic             w_ldst;

    opcode_classifier u_classifier (
        .i_opcode  (opcode),
        .o_cls     (w_cls),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_hs         = 1'b1;
        w_wait_state = 1'b0;
        case (r_state)
            ST_FETCH: begin w_hs = im_ready;  w_wait_state = 1'b1; end
            ST_EXEC:  begin w_hs = alu_valid; w_wait_state = 1'b1; end
            ST_MEM:   begin w_hs = dm_ready;  w_wait_state = 1'b1; end
            default:  ;
        endcase
    end

    // A handshake arriving on the last allowed wait cycle still wins over the trap.
    assign w_timeout = w_wait_state && !w_hs && (r_wait_cnt == TO_W'(TIMEOUT - 1));
    assign w_ldst    = (r_cls == CLS_LOAD) || (r_cls == CLS_STORE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (im_ready)       w_next = ST_DECODE;
                else if (w_timeout) w_next = ST_TRAP;
            end
            ST_DECODE: begin
                if (w_illegal)                w_next = ST_TRAP;
                else if (w_cls == CLS_SYSTEM) w_next = ST_HALT;
                else                          w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (alu_valid)      w_next = w_ldst ? ST_MEM : ST_WB;
                else if (w_timeout) w_next = ST_TRAP;
            end
            ST_MEM: begin
                if (dm_ready)       w_next = ST_WB;
                else if (w_timeout) w_next = ST_TRAP;
            end
            ST_WB:   w_next = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT: if (resume) w_next = ST_FETCH;
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_FETCH;
            r_wait_cnt   <= '0;
            r_cls        <= CLS_NONE;
            r_trap_cause <= TC_NONE;
            r_instret    <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_wait_state && !w_hs)
                r_wait_cnt <= r_wait_cnt + TO_W'(1);
            if (r_state == ST_DECODE)
                r_cls <= w_cls;
            if ((r_state == ST_DECODE) && w_illegal)
                r_trap_cause <= TC_ILLEGAL;
            else if (w_timeout)
                r_trap_cause <= TC_TIMEOUT;
            if (r_state == ST_WB)
                r_instret <= r_instret + WIDTH'(1);
        end
    end

    // Fetch outputs are gated by rst so nothing is requested while held in reset.
    always_comb begin
        im_req      = 1'b0;
        ir_load     = 1'b0;
        rf_read_en  = 1'b0;
        alu_en      = 1'b0;
        dm_read_en  = 1'b0;
        dm_write_en = 1'b0;
        rf_write_en = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        wb_sel      = WB_NONE;
        halted      = 1'b0;
        trap        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                im_req  = rst;
                ir_load = rst && im_ready;
            end
            ST_DECODE: rf_read_en = 1'b1;
            ST_EXEC:   alu_en     = 1'b1;
            ST_MEM: begin
                dm_read_en  = (r_cls == CLS_LOAD);
                dm_write_en = (r_cls == CLS_STORE);
            end
            ST_WB: begin
                pc_en       = 1'b1;
                pc_sel      = (r_cls == CLS_JAL) || (r_cls == CLS_JALR) ||
                              ((r_cls == CLS_BRANCH) && branch_taken);
                rf_write_en = (r_cls != CLS_STORE) && (r_cls != CLS_BRANCH);
                case (r_cls)
                    CLS_LOAD:                                 wb_sel = WB_LOAD;
                    CLS_JAL, CLS_JALR:                        wb_sel = WB_PC4;
                    CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC:    wb_sel = WB_ALU;
                    default:                                  wb_sel = WB_NONE;
                endcase
            end
            ST_HALT: halted = 1'b1;
            ST_TRAP: trap   = 1'b1;
            default: ;
        endcase
    end

    assign stage      = r_state;
    assign trap_cause = r_trap_cause;
    assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Cycle-by-cycle checks of the control FSM; WB results tracked through a scoreboard queue.
module tb_multicycle_sequencer;

    localparam int TMO = 16;

    typedef struct packed {
        logic       im_req, ir_load, rf_read_en, alu_en, dm_read_en, dm_write_en;
        logic       rf_write_en, pc_en, pc_sel;
        logic [1:0] wb_sel;
        logic       halted, trap;
    } outs_t;

    typedef struct packed {
        logic [1:0]  wb_sel;
        logic        pc_sel;
        logic        rf_we;
        logic [31:0] instret;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken, im_ready, alu_valid, dm_ready, halt_req, resume;
    logic        im_req, ir_load, rf_read_en, alu_en, dm_read_en, dm_write_en;
    logic        rf_write_en, pc_en, pc_sel, halted, trap;
    logic [1:0]  wb_sel, trap_cause;
    logic [2:0]  stage;
    logic [31:0] instret;
    outs_t       obs;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] n_ret = 0;
    wb_exp_t     sb[$];

    always #5 clk = ~clk;

    multicycle_sequencer #(.WIDTH(32), .TIMEOUT(TMO), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .im_ready(im_ready), .alu_valid(alu_valid), .dm_ready(dm_ready),
        .halt_req(halt_req), .resume(resume), .im_req(im_req), .ir_load(ir_load),
        .rf_read_en(rf_read_en), .alu_en(alu_en), .dm_read_en(dm_read_en),
        .dm_write_en(dm_write_en), .rf_write_en(rf_write_en), .pc_en(pc_en),
        .pc_sel(pc_sel), .wb_sel(wb_sel), .stage(stage), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .instret(instret)
    );

    always_comb obs = {im_req, ir_load, rf_read_en, alu_en, dm_read_en, dm_write_en,
                       rf_write_en, pc_en, pc_sel, wb_sel, halted, trap};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected WB behaviour per opcode; also tells which opcodes retire.
    function automatic wb_exp_t wb_of(input logic [6:0] op, input logic br);
        wb_exp_t e;
        e = '0;
        case (op)
            7'b0000011: begin e.wb_sel = 2'b10; e.rf_we = 1'b1; end
            7'b0100011: ;
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                e.wb_sel = 2'b11; e.rf_we = 1'b1;
            end
            7'b1101111, 7'b1100111: begin e.wb_sel = 2'b01; e.rf_we = 1'b1; e.pc_sel = 1'b1; end
            7'b1100011: e.pc_sel = br;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic retires(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic outs_t exp_outs(input logic [2:0] st, input logic [6:0] op,
                                       input logic im, input logic br);
        outs_t   e;
        wb_exp_t w;
        e = '0;
        w = wb_of(op, br);
        case (st)
            3'd0: begin e.im_req = 1'b1; e.ir_load = im; end
            3'd1: e.rf_read_en = 1'b1;
            3'd2: e.alu_en = 1'b1;
            3'd3: begin
                e.dm_read_en  = (op == 7'b0000011);
                e.dm_write_en = (op == 7'b0100011);
            end
            3'd4: begin
                e.pc_en = 1'b1; e.pc_sel = w.pc_sel;
                e.rf_write_en = w.rf_we; e.wb_sel = w.wb_sel;
            end
            3'd5: e.halted = 1'b1;
            3'd6: e.trap = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // One clock cycle: drive handshakes after the falling edge, then check state and outputs.
    task automatic cyc(input logic [2:0] st, input logic im, input logic alu,
                       input logic dm, input logic rs);
        wb_exp_t e;
        @(negedge clk);
        im_ready = im; alu_valid = alu; dm_ready = dm; resume = rs;
        #1;
        chk("stage", 32'(stage), 32'(st));
        chk("outs", 32'(obs), 32'(exp_outs(st, opcode, im, branch_taken)));
        if (pc_en) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("wb_sel", 32'(wb_sel), 32'(e.wb_sel));
                chk("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
                chk("rf_we", 32'(rf_write_en), 32'(e.rf_we));
                chk("instret", instret, e.instret);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; im_ready = 1'b0; alu_valid = 1'b0; dm_ready = 1'b0;
        halt_req = 1'b0; resume = 1'b0; branch_taken = 1'b0;
        @(negedge clk); #1;
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_outs", 32'(obs), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        @(posedge clk); #2;
        rst   = 1'b1;
        n_ret = '0;
    endtask

    task automatic run_instr(input logic [6:0] op, input int lat_im, input int lat_alu,
                             input int lat_dm, input logic br, input logic hreq);
        wb_exp_t e;
        logic    ldst;
        ldst = (op == 7'b0000011) || (op == 7'b0100011);
        opcode = op; branch_taken = br; halt_req = 1'b0;
        if (retires(op) && lat_im < TMO) begin
            e = wb_of(op, br);
            e.instret = n_ret;
            sb.push_back(e);
        end
        for (int i = 0; i <= lat_im; i++) begin
            if (i == TMO) begin
                cyc(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("cause_timeout", 32'(trap_cause), 32'd2);
                return;
            end
            cyc(3'd0, (i == lat_im), 1'b0, 1'b0, 1'b0);
        end
        cyc(3'd1, 1'b0, 1'b0, 1'b0, 1'b1);   // resume pulse outside HALT must be ignored
        if (!retires(op) && op != 7'b1110011) begin
            cyc(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("cause_illegal", 32'(trap_cause), 32'd1);
            return;
        end
        if (op == 7'b1110011) begin
            cyc(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        halt_req = hreq;
        for (int i = 0; i <= lat_alu; i++) cyc(3'd2, 1'b0, (i == lat_alu), 1'b0, 1'b0);
        if (ldst)
            for (int i = 0; i <= lat_dm; i++) cyc(3'd3, 1'b0, 1'b0, (i == lat_dm), 1'b0);
        cyc(3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        n_ret = n_ret + 32'd1;
    endtask

    initial begin
        opcode = 7'b0110011;
        do_reset();
        run_instr(7'b0110011, 0, 0, 0, 1'b0, 1'b0);   // ADD
        run_instr(7'b0000011, 0, 0, 3, 1'b0, 1'b0);   // LW, dm_ready late
        run_instr(7'b0100011, 2, 1, 1, 1'b0, 1'b0);   // SW
        run_instr(7'b1100011, 0, 0, 0, 1'b1, 1'b0);   // branch taken
        run_instr(7'b1100011, 0, 0, 0, 1'b0, 1'b0);   // branch not taken
        run_instr(7'b1101111, 1, 0, 0, 1'b0, 1'b0);   // JAL
        run_instr(7'b1100111, 0, 2, 0, 1'b0, 1'b0);   // JALR
        run_instr(7'b0110111, 0, 0, 0, 1'b0, 1'b0);   // LUI
        run_instr(7'b0010111, 0, 0, 0, 1'b1, 1'b0);   // AUIPC
        run_instr(7'b0010011, 0, 1, 0, 1'b0, 1'b1);   // OPIMM with halt_req
        repeat (3) cyc(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        halt_req = 1'b0;
        run_instr(7'b1110011, 0, 0, 0, 1'b0, 1'b0);   // SYSTEM halts without retiring
        cyc(3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr(7'b0110011, TMO - 1, 0, 0, 1'b0, 1'b0); // handshake on last wait cycle
        run_instr(7'b0110011, TMO, 0, 0, 1'b0, 1'b0);     // fetch timeout
        repeat (3) cyc(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        run_instr(7'b1111111, 0, 0, 0, 1'b0, 1'b0);   // illegal opcode
        repeat (19) cyc(3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cause_held", 32'(trap_cause), 32'd1);
        do_reset();
        run_instr(7'b0110011, 0, 0, 0, 1'b0, 1'b0);
        cyc(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("instret_final", instret, n_ret);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
